// File: rtl/osiris_pkg.sv
// osiris_pkg: shared state encoding and defaults for the memory arbiter
package osiris_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT_I = ST_GRANT_I,
    GRANT_D = ST_GRANT_D,
    RESP    = ST_RESP
  } state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: 8-bit wait counter that flags when it reaches LIMIT
module arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic o_expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end
  assign o_expired = cnt == 8'(LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters with a
// watchdog timeout; define ARB_ROUND_ROBIN_EN for round-robin on collisions.
module mem_arbiter
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_instr_req,
  input  logic [ADDR_WIDTH-1:0] i_instr_addr,
  output logic [DATA_WIDTH-1:0] o_instr_rdata,
  output logic                  o_instr_ack,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  input  logic [3:0]            i_data_wstrb,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_data_ack,
  output logic                  o_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_wstrb,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);
  state_t state, state_nx;
  logic any_req, pick_d, in_grant, expired, done, timed_out;
  assign any_req = i_instr_req | i_data_req;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign done = in_grant & (i_mem_ack | expired);
  assign timed_out = in_grant & ~i_mem_ack & expired;
  assign o_busy = state != IDLE;
`ifdef ARB_ROUND_ROBIN_EN
  // last_i set means the fetch port was granted most recently
  logic last_i;
  assign pick_d = i_data_req & (~i_instr_req | last_i);
  always_ff @(posedge clk) begin
    if (rst) last_i <= 1'b1;
    else if (state == IDLE && any_req) last_i <= ~pick_d;
  end
`else
  assign pick_d = i_data_req;
`endif
  arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == IDLE),
    .en       (in_grant & ~i_mem_ack),
    .o_expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (any_req ? (pick_d ? GRANT_D : GRANT_I) : IDLE) :
               (state == RESP) ? IDLE :
               done ? RESP : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_wstrb   <= '0;
      o_instr_ack   <= 1'b0;
      o_data_ack    <= 1'b0;
      o_err         <= 1'b0;
      o_instr_rdata <= '0;
      o_data_rdata  <= '0;
    end else begin
      o_instr_ack <= 1'b0;
      o_data_ack  <= 1'b0;
      o_err       <= 1'b0;
      if (state == IDLE && any_req) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= pick_d & i_data_we;
        o_mem_addr  <= pick_d ? i_data_addr : i_instr_addr;
        o_mem_wdata <= pick_d ? i_data_wdata : '0;
        o_mem_wstrb <= pick_d ? i_data_wstrb : 4'h0;
      end
      if (done) begin
        o_mem_req   <= 1'b0;
        o_err       <= timed_out;
        o_instr_ack <= state == GRANT_I;
        o_data_ack  <= state == GRANT_D;
        if (state == GRANT_I) o_instr_rdata <= timed_out ? '0 : i_mem_rdata;
        // a completed write leaves the load data untouched
        if (state == GRANT_D && (!o_mem_we || timed_out)) o_data_rdata <= timed_out ? '0 : i_mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch/data arbitration, waits, timeout and reset
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_instr_req = 1'b0, i_data_req = 1'b0, i_data_we = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] i_instr_addr = '0, i_data_addr = '0, i_data_wdata = '0, i_mem_rdata = '0;
  logic [3:0] i_data_wstrb = '0;
  logic [31:0] o_instr_rdata, o_data_rdata, o_mem_addr, o_mem_wdata;
  logic o_instr_ack, o_data_ack, o_err, o_mem_req, o_mem_we, o_busy;
  logic [3:0] o_mem_wstrb;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_rdata(o_instr_rdata), .o_instr_ack(o_instr_ack),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_wstrb(i_data_wstrb),
    .o_data_rdata(o_data_rdata), .o_data_ack(o_data_ack), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input string t, input bit d, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws, input int w,
                     input logic [31:0] rd, input logic [31:0] exp_rdata);
    if (d) begin
      i_data_req = 1'b1; i_data_we = we; i_data_addr = a; i_data_wdata = wd; i_data_wstrb = ws;
    end else begin
      i_instr_req = 1'b1; i_instr_addr = a;
    end
    chk({t, ".idle_busy"}, 32'(o_busy), 32'd0);
    step();
    for (int c = 0; c <= w; c++) begin
      chk({t, ".req"}, 32'(o_mem_req), 32'd1);
      chk({t, ".addr"}, o_mem_addr, a);
      chk({t, ".we"}, 32'(o_mem_we), 32'(d & we));
      chk({t, ".wstrb"}, 32'(o_mem_wstrb), d ? 32'(ws) : 32'd0);
      if (d && we) chk({t, ".wdata"}, o_mem_wdata, wd);
      chk({t, ".busy"}, 32'(o_busy), 32'd1);
      chk({t, ".early_ack"}, 32'({o_instr_ack, o_data_ack}), 32'd0);
      if (c == w) begin
        i_mem_ack = 1'b1; i_mem_rdata = rd;
      end
      step();
    end
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    i_instr_req = 1'b0; i_data_req = 1'b0;
    chk({t, ".ack"}, 32'({o_instr_ack, o_data_ack}), d ? 32'd1 : 32'd2);
    chk({t, ".err"}, 32'(o_err), 32'd0);
    chk({t, ".req_drop"}, 32'(o_mem_req), 32'd0);
    chk({t, ".rdata"}, d ? o_data_rdata : o_instr_rdata, exp_rdata);
    chk({t, ".resp_busy"}, 32'(o_busy), 32'd1);
    step();
    chk({t, ".ack_pulse"}, 32'({o_instr_ack, o_data_ack}), 32'd0);
    chk({t, ".done_busy"}, 32'(o_busy), 32'd0);
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst.req", 32'(o_mem_req), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.acks", 32'({o_instr_ack, o_data_ack, o_err}), 32'd0);
    chk("rst.irdata", o_instr_rdata, 32'd0);
    chk("rst.drdata", o_data_rdata, 32'd0);
    chk("rst.addr", o_mem_addr, 32'd0);
    txn("fetch0w", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    txn("dread", 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D);
    txn("dwrite", 1'b1, 1'b1, 32'h2000, 32'h12345678, 4'hF, 3, 32'hBAD0BAD0, 32'hCAFEF00D);
    // collision: data first, fetch served in the following IDLE
    i_instr_req = 1'b1; i_instr_addr = 32'h400;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h500;
    step();
    chk("coll.first_addr", o_mem_addr, 32'h500);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h11111111;
    step();
    i_mem_ack = 1'b0; i_data_req = 1'b0;
    chk("coll.data_ack", 32'({o_instr_ack, o_data_ack}), 32'd1);
    chk("coll.data_rdata", o_data_rdata, 32'h11111111);
    step();
    chk("coll.resp_ignored", 32'(o_busy), 32'd0);
    step();
    chk("coll.second_addr", o_mem_addr, 32'h400);
    chk("coll.second_we", 32'(o_mem_we), 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h22222222;
    step();
    i_mem_ack = 1'b0; i_instr_req = 1'b0;
    chk("coll.instr_ack", 32'({o_instr_ack, o_data_ack}), 32'd2);
    chk("coll.instr_rdata", o_instr_rdata, 32'h22222222);
    step();
    // timeout with limit 4: ack+err in cycle 6
    i_instr_req = 1'b1; i_instr_addr = 32'h600;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("tmo.wait_req", 32'(o_mem_req), 32'd1);
      chk("tmo.wait_ack", 32'({o_instr_ack, o_err}), 32'd0);
    end
    step();
    i_instr_req = 1'b0;
    chk("tmo.ack", 32'(o_instr_ack), 32'd1);
    chk("tmo.err", 32'(o_err), 32'd1);
    chk("tmo.rdata", o_instr_rdata, 32'd0);
    chk("tmo.req", 32'(o_mem_req), 32'd0);
    step();
    chk("tmo.err_clear", 32'(o_err), 32'd0);
    chk("tmo.busy", 32'(o_busy), 32'd0);
    // reset in the second wait cycle of a read
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h700;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; i_data_req = 1'b0;
    chk("rstmid.req", 32'(o_mem_req), 32'd0);
    chk("rstmid.busy", 32'(o_busy), 32'd0);
    chk("rstmid.acks", 32'({o_instr_ack, o_data_ack, o_err}), 32'd0);
    chk("rstmid.drdata", o_data_rdata, 32'd0);
    chk("rstmid.addr", o_mem_addr, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstmid.no_ack", 32'({o_instr_ack, o_data_ack}), 32'd0);
    end
    txn("fresh", 1'b0, 1'b0, 32'h800, 32'h0, 4'h0, 1, 32'h55AA55AA, 32'h55AA55AA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
